// File: rtl/vga_timing_gen_pkg.sv
// Default VGA 640x480@60 timing values and small helpers shared by the
// raster generator and its wrap counters.
package vga_timing_gen_pkg;

  localparam int DEF_CW       = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_WIN_SIZE = 32;

  localparam logic DEF_HS_POL = 1'b0;
  localparam logic DEF_VS_POL = 1'b0;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter that resets to MAX, so the first enabled edge lands on 0.
// D exposes the next-state value so decode logic can register with zero latency.
module vga_wrap_counter #(
  parameter int              CW  = 10,
  parameter logic [CW-1:0]   MAX = '1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  output logic [CW-1:0] Q,
  output logic [CW-1:0] D,
  output logic          Wrap
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Enable) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q    = cnt_q;
  assign D    = cnt_d;
  assign Wrap = Enable && (cnt_q == MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame/line strobes and a
// frame-synchronous, double-buffered square overlay window.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   CW       = DEF_CW,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL,
  parameter int   WIN_SIZE = DEF_WIN_SIZE
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  input  logic [CW-1:0] iWinX,
  input  logic [CW-1:0] iWinY,
  output logic [CW-1:0] oHcounter,
  output logic [CW-1:0] oVcounter,
  output logic          oHsync,
  output logic          oVsync,
  output logic          oActive,
  output logic          oInWindow,
  output logic          oLineEnd,
  output logic          oFrameStart
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  // Thresholds carry one spare bit so sync/window bounds never wrap.
  localparam logic [CW:0] H_ACT_L  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG_L = (CW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CW:0] HS_END_L = (CW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW:0] H_LAST_L = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_ACT_L  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG_L = (CW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CW:0] VS_END_L = (CW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW:0] WIN_L    = (CW+1)'(WIN_SIZE);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          h_wrap, v_wrap;

  vga_wrap_counter #(.CW(CW), .MAX(CW'(H_TOTAL - 1))) u_hcnt (
    .Clock (Clock), .Reset (Reset), .Enable (Enable),
    .Q (h_q), .D (h_d), .Wrap (h_wrap)
  );

  vga_wrap_counter #(.CW(CW), .MAX(CW'(V_TOTAL - 1))) u_vcnt (
    .Clock (Clock), .Reset (Reset), .Enable (h_wrap),
    .Q (v_q), .D (v_d), .Wrap (v_wrap)
  );

  logic [CW-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [CW:0]   hx, vx, wxx, wyx;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d, inw_q, inw_d;
  logic          le_q, le_d, fs_q, fs_d;

  // The V counter wrapping is exactly the edge that enters (0,0).
  always_comb begin
    fs_d = v_wrap;
    wx_d = wx_q;
    wy_d = wy_q;
    if (v_wrap) begin
      wx_d = iWinX;
      wy_d = iWinY;
    end
    hx    = {1'b0, h_d};
    vx    = {1'b0, v_d};
    wxx   = {1'b0, wx_d};
    wyx   = {1'b0, wy_d};
    act_d = (hx < H_ACT_L) && (vx < V_ACT_L);
    inw_d = act_d && (hx >= wxx) && (hx < wxx + WIN_L)
                  && (vx >= wyx) && (vx < wyx + WIN_L);
    hs_d  = ((hx >= HS_BEG_L) && (hx < HS_END_L)) ? HS_POL : ~HS_POL;
    vs_d  = ((vx >= VS_BEG_L) && (vx < VS_END_L)) ? VS_POL : ~VS_POL;
    le_d  = (hx == H_LAST_L);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wx_q  <= '0;
      wy_q  <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b0;
      inw_q <= 1'b0;
      le_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (Enable) begin
      wx_q  <= wx_d;
      wy_q  <= wy_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      inw_q <= inw_d;
      le_q  <= le_d;
      fs_q  <= fs_d;
    end
  end

  assign oHcounter   = h_q;
  assign oVcounter   = v_q;
  assign oHsync      = hs_q;
  assign oVsync      = vs_q;
  assign oActive     = act_q;
  assign oInWindow   = inw_q;
  assign oLineEnd    = le_q;
  assign oFrameStart = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-mode instance under random enable/window
// stimulus and a default 640x480 instance, both checked every cycle against a
// pixel-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int hp; int vp; int win;
  } cfg_t;

  typedef struct packed {
    int h; int v; int hs; int vs; int act; int inw; int le; int fs;
  } exp_t;

  localparam cfg_t CA = '{8, 2, 3, 1, 6, 1, 2, 1, 1, 0, 3};
  localparam cfg_t CB = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 32};
  localparam int FT_A = 14 * 10;
  localparam int FT_B = 800 * 525;

  logic clk = 1'b0;
  logic rst, en_a, en_b;
  logic [4:0] wxa_i, wya_i, h_a, v_a;
  logic [9:0] wxb_i, wyb_i, h_b, v_b;
  logic hs_a, vs_a, act_a, inw_a, le_a, fs_a;
  logic hs_b, vs_b, act_b, inw_b, le_b, fs_b;

  int tests = 0;
  int fails = 0;
  int pix_a, pix_b, lwx_a, lwy_a, lwx_b, lwy_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CW(5), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .WIN_SIZE(3)
  ) dut_a (
    .Clock(clk), .Reset(rst), .Enable(en_a), .iWinX(wxa_i), .iWinY(wya_i),
    .oHcounter(h_a), .oVcounter(v_a), .oHsync(hs_a), .oVsync(vs_a),
    .oActive(act_a), .oInWindow(inw_a), .oLineEnd(le_a), .oFrameStart(fs_a)
  );

  vga_timing_gen dut_b (
    .Clock(clk), .Reset(rst), .Enable(en_b), .iWinX(wxb_i), .iWinY(wyb_i),
    .oHcounter(h_b), .oVcounter(v_b), .oHsync(hs_b), .oVsync(vs_b),
    .oActive(act_b), .oInWindow(inw_b), .oLineEnd(le_b), .oFrameStart(fs_b)
  );

  // Position follows purely from how many enabled pixels have elapsed.
  function automatic exp_t model(input cfg_t c, input int pix, input int wx, input int wy);
    exp_t e;
    int ht, vt;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    if (pix < 0) begin
      e = '{ht - 1, vt - 1, 1 - c.hp, 1 - c.vp, 0, 0, 0, 0};
    end else begin
      e.h   = pix % ht;
      e.v   = (pix / ht) % vt;
      e.act = (e.h < c.ha && e.v < c.va) ? 1 : 0;
      e.hs  = (e.h >= c.ha + c.hf && e.h < c.ha + c.hf + c.hsw) ? c.hp : 1 - c.hp;
      e.vs  = (e.v >= c.va + c.vf && e.v < c.va + c.vf + c.vsw) ? c.vp : 1 - c.vp;
      e.inw = (e.act == 1 && e.h >= wx && e.h < wx + c.win &&
               e.v >= wy && e.v < wy + c.win) ? 1 : 0;
      e.le  = (e.h == ht - 1) ? 1 : 0;
      e.fs  = (e.h == 0 && e.v == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (pix_a=%0d pix_b=%0d)",
               name, act, exp, pix_a, pix_b);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = model(CA, pix_a, lwx_a, lwy_a);
    chk("A.h", int'(h_a), e.h);       chk("A.v", int'(v_a), e.v);
    chk("A.hsync", int'(hs_a), e.hs); chk("A.vsync", int'(vs_a), e.vs);
    chk("A.active", int'(act_a), e.act);
    chk("A.inwin", int'(inw_a), e.inw);
    chk("A.lineend", int'(le_a), e.le);
    chk("A.framestart", int'(fs_a), e.fs);
    e = model(CB, pix_b, lwx_b, lwy_b);
    chk("B.h", int'(h_b), e.h);       chk("B.v", int'(v_b), e.v);
    chk("B.hsync", int'(hs_b), e.hs); chk("B.vsync", int'(vs_b), e.vs);
    chk("B.active", int'(act_b), e.act);
    chk("B.inwin", int'(inw_b), e.inw);
    chk("B.lineend", int'(le_b), e.le);
    chk("B.framestart", int'(fs_b), e.fs);
    if (pix_b == 655) chk("B.hsync@655 lit", int'(hs_b), 1);
    if (pix_b == 656) chk("B.hsync@656 lit", int'(hs_b), 0);
    if (pix_b == 751) chk("B.hsync@751 lit", int'(hs_b), 0);
    if (pix_b == 752) chk("B.hsync@752 lit", int'(hs_b), 1);
    if (pix_b == 799) chk("B.lineend@799 lit", int'(le_b), 1);
    if (pix_b == 800) chk("B.v@800 lit", int'(v_b), 1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (en_a) begin
        if ((pix_a + 1) % FT_A == 0) begin lwx_a = int'(wxa_i); lwy_a = int'(wya_i); end
        pix_a++;
      end
      if (en_b) begin
        if ((pix_b + 1) % FT_B == 0) begin lwx_b = int'(wxb_i); lwy_b = int'(wyb_i); end
        pix_b++;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic model_reset();
    pix_a = -1; pix_b = -1;
    lwx_a = 0; lwy_a = 0; lwx_b = 0; lwy_b = 0;
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    wxa_i = 5'd5; wya_i = 5'd2; wxb_i = 10'd10; wyb_i = 10'd0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("A.reset h lit", int'(h_a), 13);
    chk("A.reset v lit", int'(v_a), 9);
    chk("B.reset h lit", int'(h_b), 799);
    chk("B.reset v lit", int'(v_b), 524);
    rst = 1'b0;
    step();
    chk("A.idle after release h lit", int'(h_a), 13);
    en_a = 1'b1; en_b = 1'b1;

    // Directed: first frame with window (5,2), moved to (0,0) mid-frame.
    step();
    chk("A.first fs lit", int'(fs_a), 1);
    chk("A.first h lit", int'(h_a), 0);
    repeat (10) step();
    chk("A.hsync h=10 lit", int'(hs_a), 1);
    repeat (3) step();
    chk("A.lineend h=13 lit", int'(le_a), 1);
    chk("A.hsync h=13 lit", int'(hs_a), 0);
    repeat (20) step();
    chk("A.inwin (5,2) lit", int'(inw_a), 1);
    wxa_i = 5'd0; wya_i = 5'd0;
    repeat (2) step();
    chk("A.inwin (7,2) old window lit", int'(inw_a), 1);
    while (pix_a < FT_A) step();
    chk("A.new frame fs lit", int'(fs_a), 1);
    chk("A.new window (0,0) lit", int'(inw_a), 1);

    // Clipped window: only column 7 of the active area.
    wxa_i = 5'd7; wya_i = 5'd1;
    while (pix_a < 2 * FT_A + 14 + 7) step();
    chk("A.clipped inwin (7,1) lit", int'(inw_a), 1);
    step();
    chk("A.clipped none past edge lit", int'(inw_a), 0);

    // Enable toggling every cycle.
    for (int i = 0; i < 300; i++) begin
      en_a = ~en_a;
      step();
    end

    // Random enable and window moves.
    for (int i = 0; i < 3000; i++) begin
      en_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        wxa_i = 5'($urandom_range(0, 15));
        wya_i = 5'($urandom_range(0, 10));
        wxb_i = 10'($urandom_range(0, 700));
        wyb_i = 10'($urandom_range(0, 4));
      end
      step();
    end

    // Asynchronous reset pulse mid-line at h=300 of the default instance.
    en_a = 1'b1;
    for (int k = 0; k < 1000 && (pix_b % 800) != 300; k++) step();
    chk("B.h before reset", int'(h_b), 300);
    rst = 1'b1;
    #1;
    model_reset();
    chk("B.async reset h lit", int'(h_b), 799);
    chk("B.async reset v lit", int'(v_b), 524);
    chk("A.async reset h lit", int'(h_a), 13);
    chk("A.async reset v lit", int'(v_a), 9);
    step();
    rst = 1'b0;
    step();
    chk("B.restart fs lit", int'(fs_b), 1);
    repeat (400) begin
      en_a = ($urandom_range(0, 1) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
